// File: rtl/cpu_pkg.sv
// Shared CPU definitions: fetch FSM state type, PC width and the NOP encoding that
// the datapath substitutes for squashed instructions.
package cpu_pkg;

  localparam int unsigned PC_W = 12;
  localparam logic [31:0] NOP  = 32'h0000_0013;

  typedef enum logic [0:0] {
    StRun,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/sat_counter.sv
// Up-counter that sticks at all-ones instead of wrapping; synchronous clear wins over enable.
module sat_counter #(
  parameter int unsigned Width = 16
) (
  input  logic             clk,
  input  logic             clr_i,
  input  logic             en_i,
  output logic [Width-1:0] count_o
);

  logic [Width-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (en_i && (cnt_q != '1)) begin
      cnt_d = cnt_q + Width'(1);
    end
  end

  always_ff @(posedge clk) begin
    cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_sequencer.sv
// Fetch PC sequencer: tracks PC of fetch and EX stages, squashes wrong-path fetches after a
// redirect and supports halt/resume. All state is registered; squash_ex has no input path.
module fetch_sequencer #(
  parameter int unsigned        PC_W     = cpu_pkg::PC_W,
  parameter logic [PC_W-1:0]    RESET_PC = '0,
  parameter int unsigned        CNT_W    = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             branch_taken_ex,
  input  logic             jump_ex,
  input  logic [PC_W-1:0]  target_ex,
  input  logic             halt_req,
  input  logic             resume,
  output logic [PC_W-1:0]  pc_f,
  output logic [PC_W-1:0]  pc_ex,
  output logic             squash_ex,
  output logic             halted,
  output logic [CNT_W-1:0] redirect_cnt
);

  import cpu_pkg::*;

  fetch_state_e    state_q, state_d;
  logic [PC_W-1:0] pc_f_q, pc_f_d;
  logic [PC_W-1:0] pc_ex_q, pc_ex_d;
  logic            ex_valid_q, ex_valid_d;
  logic            redirect;

  // A squashed EX slot can never redirect; ex_valid is always 0 in halt.
  assign redirect = (branch_taken_ex | jump_ex) & ex_valid_q;

  always_comb begin
    state_d    = state_q;
    pc_f_d     = pc_f_q;
    pc_ex_d    = pc_ex_q;
    ex_valid_d = ex_valid_q;
    unique case (state_q)
      StRun: begin
        pc_ex_d = pc_f_q;
        if (halt_req) begin
          state_d    = StHalt;
          ex_valid_d = 1'b0;
          if (redirect) begin
            pc_f_d = target_ex;
          end
        end else if (redirect) begin
          pc_f_d     = target_ex;
          ex_valid_d = 1'b0;
        end else begin
          pc_f_d     = pc_f_q + PC_W'(1);
          ex_valid_d = 1'b1;
        end
      end
      StHalt: begin
        ex_valid_d = 1'b0;
        if (resume) begin
          state_d = StRun;
        end
      end
      default: begin
        state_d    = StRun;
        ex_valid_d = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StRun;
      pc_f_q     <= RESET_PC;
      pc_ex_q    <= RESET_PC;
      ex_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc_f_q     <= pc_f_d;
      pc_ex_q    <= pc_ex_d;
      ex_valid_q <= ex_valid_d;
    end
  end

  sat_counter #(
    .Width (CNT_W)
  ) u_redirect_cnt (
    .clk     (clk),
    .clr_i   (rst),
    .en_i    (redirect),
    .count_o (redirect_cnt)
  );

  assign pc_f      = pc_f_q;
  assign pc_ex     = pc_ex_q;
  assign squash_ex = ~ex_valid_q;
  assign halted    = (state_q == StHalt);

endmodule

// File: tb/tb_fetch_sequencer.sv
// Bench for fetch_sequencer: directed scenarios with literal expectations, then random
// stimulus checked every cycle against a behavioural model. A narrow-counter instance
// shares the stimulus to exercise saturation quickly.
module tb_fetch_sequencer;

  localparam int unsigned PcW = 12;

  logic           clk = 1'b0;
  logic           rst, branch_taken_ex, jump_ex, halt_req, resume;
  logic [PcW-1:0] target_ex;
  logic [PcW-1:0] pc_f, pc_ex, pc_f_s, pc_ex_s;
  logic           squash_ex, halted, squash_ex_s, halted_s;
  logic [15:0]    redirect_cnt;
  logic [2:0]     redirect_cnt_s;

  int tests = 0;
  int fails = 0;

  // Behavioural model state.
  int  m_pc_f, m_pc_ex, m_cnt, m_cnt_s;
  bit  m_valid, m_halt;

  always #5 clk = ~clk;

  fetch_sequencer #(.PC_W(PcW), .RESET_PC(12'h000), .CNT_W(16)) dut (
    .clk             (clk),
    .rst             (rst),
    .branch_taken_ex (branch_taken_ex),
    .jump_ex         (jump_ex),
    .target_ex       (target_ex),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc_f            (pc_f),
    .pc_ex           (pc_ex),
    .squash_ex       (squash_ex),
    .halted          (halted),
    .redirect_cnt    (redirect_cnt)
  );

  fetch_sequencer #(.PC_W(PcW), .RESET_PC(12'h000), .CNT_W(3)) dut_s (
    .clk             (clk),
    .rst             (rst),
    .branch_taken_ex (branch_taken_ex),
    .jump_ex         (jump_ex),
    .target_ex       (target_ex),
    .halt_req        (halt_req),
    .resume          (resume),
    .pc_f            (pc_f_s),
    .pc_ex           (pc_ex_s),
    .squash_ex       (squash_ex_s),
    .halted          (halted_s),
    .redirect_cnt    (redirect_cnt_s)
  );

  task automatic chk(input string name, input int act, input int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle of inputs, advance the model across the edge, then compare.
  task automatic cycle(input bit r, input bit b, input bit j, input int t,
                       input bit h, input bit res);
    bit take;
    rst = r; branch_taken_ex = b; jump_ex = j; target_ex = PcW'(t);
    halt_req = h; resume = res;
    if (r) begin
      m_pc_f = 0; m_pc_ex = 0; m_valid = 0; m_halt = 0; m_cnt = 0; m_cnt_s = 0;
    end else if (m_halt) begin
      m_valid = 0;
      if (res) m_halt = 0;
    end else begin
      take = (b || j) && m_valid;
      m_pc_ex = m_pc_f;
      if (take) begin
        m_cnt   = (m_cnt   < 65535) ? m_cnt + 1   : m_cnt;
        m_cnt_s = (m_cnt_s < 7)     ? m_cnt_s + 1 : m_cnt_s;
      end
      if (h) begin
        m_halt  = 1;
        m_valid = 0;
        if (take) m_pc_f = t % 4096;
      end else if (take) begin
        m_pc_f  = t % 4096;
        m_valid = 0;
      end else begin
        m_pc_f  = (m_pc_f + 1) % 4096;
        m_valid = 1;
      end
    end
    @(posedge clk);
    @(negedge clk);
    chk("pc_f",        int'(pc_f),           m_pc_f);
    chk("pc_ex",       int'(pc_ex),          m_pc_ex);
    chk("squash_ex",   int'(squash_ex),      int'(!m_valid));
    chk("halted",      int'(halted),         int'(m_halt));
    chk("redirect_cnt", int'(redirect_cnt),  m_cnt);
    chk("redirect_cnt_narrow", int'(redirect_cnt_s), m_cnt_s);
  endtask

  task automatic idle();
    cycle(0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    // Reset, then free-run from RESET_PC.
    cycle(1, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 12'h123, 0, 0);
    chk("rst_pc_f", int'(pc_f), 0);
    chk("rst_squash", int'(squash_ex), 1);
    chk("rst_cnt", int'(redirect_cnt), 0);
    for (int k = 1; k <= 5; k++) begin
      idle();
      chk("run_pc_f", int'(pc_f), k);
      chk("run_pc_ex", int'(pc_ex), k - 1);
      chk("run_squash", int'(squash_ex), 0);
    end

    // Jump at pc_f=5 to 0x040: one bubble, target valid in EX two edges later.
    cycle(0, 0, 1, 12'h040, 0, 0);
    chk("jmp_pc_f", int'(pc_f), 12'h040);
    chk("jmp_squash", int'(squash_ex), 1);
    chk("jmp_cnt", int'(redirect_cnt), 1);
    idle();
    chk("jmp_pc_ex", int'(pc_ex), 12'h040);
    chk("jmp_valid", int'(squash_ex), 0);

    // Branch held two cycles: second lands on a squashed slot and is ignored.
    cycle(0, 1, 0, 12'h020, 0, 0);
    cycle(0, 1, 0, 12'h080, 0, 0);
    chk("br2_pc_f", int'(pc_f), 12'h021);
    chk("br2_cnt", int'(redirect_cnt), 2);

    // Wrap from 0xFFF to 0x000 without a bubble.
    cycle(0, 0, 1, 12'hFFF, 0, 0);
    idle();
    idle();
    chk("wrap_pc_ex", int'(pc_ex), 0);
    chk("wrap_squash", int'(squash_ex), 0);
    chk("wrap_pc_f", int'(pc_f), 1);

    // Halt together with a jump: freeze at target, ignore everything but resume.
    cycle(0, 0, 1, 12'h100, 1, 0);
    for (int k = 0; k < 10; k++) begin
      cycle(0, 1'($urandom), 1'($urandom), int'($urandom_range(0, 4095)), 1'($urandom), 0);
      chk("halt_pc_f", int'(pc_f), 12'h100);
      chk("halt_flag", int'(halted), 1);
      chk("halt_squash", int'(squash_ex), 1);
    end
    cycle(0, 0, 0, 0, 0, 1);
    chk("resume_squash", int'(squash_ex), 1);
    idle();
    chk("resume_pc_ex", int'(pc_ex), 12'h100);
    chk("resume_valid", int'(squash_ex), 0);

    // halt_req beats resume in RUN; reset during HALT clears everything.
    cycle(0, 0, 0, 0, 1, 1);
    chk("hr_halted", int'(halted), 1);
    cycle(1, 0, 1, 12'h200, 0, 1);
    chk("rst_halt_pc_f", int'(pc_f), 0);
    chk("rst_halt_flag", int'(halted), 0);
    chk("rst_halt_cnt", int'(redirect_cnt), 0);

    // Saturation of the narrow counter.
    idle();
    for (int k = 0; k < 9; k++) begin
      cycle(0, 0, 1, 12'h010, 0, 0);
      idle();
    end
    chk("sat_cnt", int'(redirect_cnt), 9);
    chk("sat_cnt_narrow", int'(redirect_cnt_s), 7);

    // Random traffic.
    for (int k = 0; k < 3000; k++) begin
      cycle(($urandom_range(0, 99) == 0), ($urandom_range(0, 3) == 0),
            ($urandom_range(0, 5) == 0), int'($urandom_range(0, 4095)),
            ($urandom_range(0, 19) == 0), ($urandom_range(0, 3) == 0));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

Interface
REQ-001 Parameter PC_W, default 12: width of word-addressed PC (4096-word instruction RAM).
REQ-002 Parameter RESET_PC, default 12'h000: PC value loaded by reset.
REQ-003 Parameter CNT_W, default 16: width of redirect performance counter.
REQ-004 Port clk  input  1: single clock, all state on rising edge.
REQ-005 Port rst  input  1: reset, synchronous, active-high.
REQ-006 Port branch_taken_ex  input  1: EX-stage conditional branch resolved taken.
REQ-007 Port jump_ex  input  1: EX-stage instruction is jal/jalr.
REQ-008 Port target_ex  input  PC_W: redirect target word address from EX stage.
REQ-009 Port halt_req  input  1: request to stop fetching (single-cycle pulse or level).
REQ-010 Port resume  input  1: request to restart fetching from held PC.
REQ-011 Port pc_f  output  PC_W: address presented to instruction RAM this cycle.
REQ-012 Port pc_ex  output  PC_W: PC of instruction currently in EX.
REQ-013 Port squash_ex  output  1: EX instruction invalid; datapath gates regwrite, gpio_we, and treats it as NOP.
REQ-014 Port halted  output  1: high while in HALT state.
REQ-015 Port redirect_cnt  output  CNT_W: count of accepted redirects.

Function
REQ-016 Datapath latches inst_ram[pc_f] into EX every edge; this block SHALL track EX validity in a register ex_valid, with squash_ex = ~ex_valid (registered, no combinational path from inputs).
REQ-017 redirect = (branch_taken_ex | jump_ex) & ex_valid; redirect inputs SHALL be ignored while squash_ex is high.
REQ-018 States: RUN, HALT (2-state FSM).
REQ-019 RUN, no redirect, no halt_req: pc_f <= pc_f+1, pc_ex <= pc_f, ex_valid <= 1.
REQ-020 RUN, redirect: pc_f <= target_ex, pc_ex <= pc_f, ex_valid <= 0 (one-cycle bubble for wrong-path fetch), redirect_cnt increments.
REQ-021 PC increment SHALL wrap modulo 2^PC_W (4095 -> 0), no error flag.
REQ-022 redirect_cnt SHALL saturate at all-ones; no wrap.
REQ-023 RUN, halt_req: state <= HALT, ex_valid <= 0, pc_ex <= pc_f; pc_f holds unless a redirect occurs the same cycle, in which case pc_f <= target_ex and the counter increments.
REQ-024 RUN: resume SHALL be ignored; halt_req wins over resume when both are high.
REQ-025 HALT: pc_f and pc_ex hold, ex_valid held 0, halt_req ignored, halted = 1.
REQ-026 HALT, resume: state <= RUN, ex_valid stays 0 that edge; the first valid EX instruction is at held pc_f one cycle later.
REQ-027 Latency: the first instruction after a redirect reaches EX valid exactly 2 edges after the redirect cycle.

Reset
REQ-028 While rst is high at an edge: pc_f <= RESET_PC, pc_ex <= RESET_PC, ex_valid <= 0 (squash_ex = 1), state <= RUN, halted <= 0, redirect_cnt <= 0.
REQ-029 Reset SHALL override all inputs, including mid-HALT and a same-cycle redirect; the first fetch is at RESET_PC on the first edge after rst falls.

Structure
REQ-030 Shared package cpu_pkg SHALL hold the typedef of the FSM state enum (RUN, HALT), PC_W, and NOP constant 32'h00000013 used by the datapath for squashed instructions.
REQ-031 One sub-module, sat_counter (parameterised width, enable, synchronous active-high clear), SHALL implement redirect_cnt.
REQ-032 The CPU top SHALL replace its inline PC_F/PC_EX logic with this block and AND regwrite/gpio_we with ~squash_ex.

Verification
REQ-033 Reset release, 4 idle cycles -> pc_f 0,1,2,3,4; squash_ex 1 on first cycle, then 0; pc_ex lags pc_f by one.
REQ-034 jump_ex=1, target_ex=12'h040 at pc_f=5 -> next pc_f=0x040, squash_ex=1 one cycle, pc_ex=0x040 with squash_ex=0 two edges later, redirect_cnt=1.
REQ-035 branch_taken_ex held high for 2 consecutive cycles -> only the first accepted (second squashed), redirect_cnt=1.
REQ-036 pc_f=12'hFFF free-running -> next pc_f=0x000, squash_ex stays 0.
REQ-037 halt_req with jump_ex target 0x100 same cycle -> halted=1, pc_f frozen at 0x100 for 10 cycles, squash_ex=1; resume -> pc_ex=0x100 valid 2 edges later.
REQ-038 Force redirect_cnt to 0xFFFE, 3 redirects -> 0xFFFF held; rst asserted during HALT -> pc_f=0, halted=0, redirect_cnt=0.
